// File: rtl/pc_unit.sv
// pc_unit: fetch program counter with boot/run/stall/halt sequencing, branch/jump
// target generation, misalignment trap and accepted-update counter.
module pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  input  logic        stall,
  input  logic        halt,
  input  logic [15:0] imm16,
  input  logic [25:0] instr26,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] branch_target,
  output logic [31:0] jump_target,
  output logic        pc_valid,
  output logic        align_err,
  output logic [31:0] err_pc,
  output logic [31:0] instr_count
);
  typedef enum logic [1:0] {BOOT, RUN, STALL, HALTED} state_t;
  state_t state, state_n;
  logic load, trap;
  assign pc_plus4      = pc + 32'd4;
  assign branch_target = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
  assign jump_target   = {pc_plus4[31:28], instr26, 2'b00};
  // Halt beats stall, stall beats the alignment check, all three block the load.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    trap    = 1'b0;
    case (state)
      BOOT:  state_n = RUN;
      RUN: begin
        if (halt) state_n = HALTED;
        else if (stall) state_n = STALL;
        else if (|next_pc[1:0]) begin
          state_n = HALTED;
          trap    = 1'b1;
        end else load = 1'b1;
      end
      STALL: state_n = halt ? HALTED : stall ? STALL : RUN;
      default: state_n = HALTED;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      pc_valid    <= 1'b0;
      align_err   <= 1'b0;
      err_pc      <= 32'h0;
      instr_count <= 32'h0;
    end else begin
      state    <= state_n;
      pc_valid <= (state_n == RUN) || (state_n == STALL);
      if (load) begin
        pc          <= next_pc;
        instr_count <= instr_count + 32'd1;
      end
      if (trap) begin
        align_err <= 1'b1;
        err_pc    <= next_pc;
      end
    end
  end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scoreboard bench for pc_unit; expected register state is
// queued with each stimulus step and compared after the DUT's clock edge.
module tb_pc_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] next_pc;
  logic        stall;
  logic        halt;
  logic [15:0] imm16;
  logic [25:0] instr26;
  logic [31:0] pc, pc_plus4, branch_target, jump_target, err_pc, instr_count;
  logic        pc_valid, align_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        valid;
    logic        aerr;
    logic [31:0] epc;
    logic [31:0] cnt;
  } exp_t;
  exp_t sb[$];

  pc_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .next_pc(next_pc), .stall(stall), .halt(halt),
    .imm16(imm16), .instr26(instr26), .pc(pc), .pc_plus4(pc_plus4),
    .branch_target(branch_target), .jump_target(jump_target), .pc_valid(pc_valid),
    .align_err(align_err), .err_pc(err_pc), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] p, input logic v,
                      input logic a, input logic [31:0] e, input logic [31:0] c);
    exp_t x;
    x.tag = tag; x.pc = p; x.valid = v; x.aerr = a; x.epc = e; x.cnt = c;
    sb.push_back(x);
  endtask

  task automatic drain;
    exp_t x;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      chk({x.tag, ".pc"}, pc, x.pc);
      chk({x.tag, ".valid"}, {31'h0, pc_valid}, {31'h0, x.valid});
      chk({x.tag, ".align_err"}, {31'h0, align_err}, {31'h0, x.aerr});
      chk({x.tag, ".err_pc"}, err_pc, x.epc);
      chk({x.tag, ".count"}, instr_count, x.cnt);
    end
  endtask

  task automatic drive(input logic s, input logic h, input logic [31:0] np);
    stall = s; halt = h; next_pc = np;
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    drain();
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 push(tag, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    drain();
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; imm16 = 16'h0; instr26 = 26'h0;
    drive(1'b0, 1'b0, 32'h0);
    #1 push("reset", 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    drain();
    @(negedge clk) rst_n = 1'b1;

    // boot then sequential fetch: 0,0,4,8,C
    drive(1'b0, 1'b0, 32'h4); push("boot", 32'h0, 1'b1, 1'b0, 32'h0, 32'd0); tick();
    drive(1'b0, 1'b0, 32'h4); push("seq1", 32'h4, 1'b1, 1'b0, 32'h0, 32'd1); tick();
    drive(1'b0, 1'b0, 32'h8); push("seq2", 32'h8, 1'b1, 1'b0, 32'h0, 32'd2); tick();
    drive(1'b0, 1'b0, 32'hC); push("seq3", 32'hC, 1'b1, 1'b0, 32'h0, 32'd3); tick();

    // three stall edges, exit edge, then load
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h20); push("stall", 32'hC, 1'b1, 1'b0, 32'h0, 32'd3); tick();
    end
    drive(1'b0, 1'b0, 32'h20); push("stall_exit", 32'hC, 1'b1, 1'b0, 32'h0, 32'd3); tick();
    drive(1'b0, 1'b0, 32'h20); push("stall_load", 32'h20, 1'b1, 1'b0, 32'h0, 32'd4); tick();

    // target generation at PC=0x00400010
    drive(1'b0, 1'b0, 32'h0040_0010); push("ld_br", 32'h0040_0010, 1'b1, 1'b0, 32'h0, 32'd5); tick();
    drive(1'b1, 1'b0, 32'h0);
    imm16 = 16'hFFFE; instr26 = 26'h0000100; #1;
    chk("pc_plus4", pc_plus4, 32'h0040_0014);
    chk("br_neg", branch_target, 32'h0040_000C);
    chk("jump", jump_target, 32'h0000_0400);
    imm16 = 16'h0003; #1;
    chk("br_pos", branch_target, 32'h0040_0020);
    push("stall_tgt", 32'h0040_0010, 1'b1, 1'b0, 32'h0, 32'd5); tick();
    drive(1'b0, 1'b0, 32'h0); push("stall_tgt_exit", 32'h0040_0010, 1'b1, 1'b0, 32'h0, 32'd5); tick();

    // self-loop counts as an update
    drive(1'b0, 1'b0, 32'h0040_0010); push("self_loop", 32'h0040_0010, 1'b1, 1'b0, 32'h0, 32'd6); tick();

    // counter wrap
    force dut.instr_count = 32'hFFFF_FFFE;
    #1 release dut.instr_count;
    drive(1'b0, 1'b0, 32'h100); push("cnt_max", 32'h100, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF); tick();
    drive(1'b0, 1'b0, 32'h104); push("cnt_wrap", 32'h104, 1'b1, 1'b0, 32'h0, 32'h0); tick();

    // misaligned trap, then frozen
    drive(1'b0, 1'b0, 32'h6); push("misalign", 32'h104, 1'b0, 1'b1, 32'h6, 32'h0); tick();
    drive(1'b0, 1'b0, 32'h8); push("halt_frz1", 32'h104, 1'b0, 1'b1, 32'h6, 32'h0); tick();
    drive(1'b1, 1'b1, 32'h7); push("halt_frz2", 32'h104, 1'b0, 1'b1, 32'h6, 32'h0); tick();
    async_reset("rst_halted");

    // stall+halt together in RUN -> HALTED
    drive(1'b0, 1'b0, 32'h40); push("boot2", 32'h0, 1'b1, 1'b0, 32'h0, 32'd0); tick();
    drive(1'b1, 1'b1, 32'h40); push("stall_halt", 32'h0, 1'b0, 1'b0, 32'h0, 32'd0); tick();
    drive(1'b0, 1'b0, 32'h40); push("halt_sticky", 32'h0, 1'b0, 1'b0, 32'h0, 32'd0); tick();
    async_reset("rst_mid_halt");

    // halt from STALL, and reset mid-STALL
    drive(1'b0, 1'b0, 32'h10); push("boot3", 32'h0, 1'b1, 1'b0, 32'h0, 32'd0); tick();
    drive(1'b0, 1'b0, 32'h10); push("ld3", 32'h10, 1'b1, 1'b0, 32'h0, 32'd1); tick();
    drive(1'b1, 1'b0, 32'h14); push("stall3", 32'h10, 1'b1, 1'b0, 32'h0, 32'd1); tick();
    async_reset("rst_mid_stall");
    drive(1'b0, 1'b0, 32'h10); push("boot4", 32'h0, 1'b1, 1'b0, 32'h0, 32'd0); tick();
    drive(1'b1, 1'b0, 32'h10); push("stall4", 32'h0, 1'b1, 1'b0, 32'h0, 32'd0); tick();
    drive(1'b0, 1'b1, 32'h10); push("stall_halt4", 32'h0, 1'b0, 1'b0, 32'h0, 32'd0); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000: PC value loaded on reset; word-aligned.
REQ-002 Clk  input  1  system clock; all state updates on rising edge.
REQ-003 Reset_n  input  1  reset, asynchronous, active-low.
REQ-004 NextPC  input  32  next-PC candidate from the downstream 4:1 PC-source mux Result.
REQ-005 Stall  input  1  hold PC this cycle.
REQ-006 Halt  input  1  stop fetch; sticky until reset.
REQ-007 Imm16  input  16  branch offset in words, two's complement.
REQ-008 Instr26  input  26  jump word index.
REQ-009 PC  output  32  current fetch address (registered).
REQ-010 PCPlus4  output  32  mux candidate R0.
REQ-011 BranchTarget  output  32  mux candidate R1.
REQ-012 JumpTarget  output  32  mux candidate R2.
REQ-013 PCValid  output  1  PC is a valid fetch address (registered).
REQ-014 AlignErr  output  1  sticky misaligned-NextPC flag (registered).
REQ-015 ErrPC  output  32  offending NextPC captured with AlignErr.
REQ-016 InstrCount  output  32  count of accepted PC updates.

Function
REQ-017 The block SHALL implement states BOOT, RUN, STALL, HALTED.
REQ-018 PCPlus4 SHALL be PC+4 modulo 2^32, combinational.
REQ-019 BranchTarget SHALL be PCPlus4 + (sign-extended Imm16 << 2), modulo 2^32, combinational.
REQ-020 JumpTarget SHALL be {PCPlus4[31:28], Instr26, 2'b00}, combinational.
REQ-021 BOOT: next edge -> RUN unconditionally; PC held; PCValid 0 while in BOOT.
REQ-022 PCValid SHALL be 1 in RUN and STALL, 0 in BOOT and HALTED.
REQ-023 RUN, per edge, priority order: Halt=1 -> HALTED, PC held; else Stall=1 -> STALL, PC held; else NextPC[1:0]!=0 -> HALTED, AlignErr<=1, ErrPC<=NextPC, PC held; else PC<=NextPC, InstrCount<=InstrCount+1, stay RUN.
REQ-024 STALL: Halt=1 -> HALTED; else Stall=1 -> stay; else -> RUN; PC never loaded in STALL, including the exit edge.
REQ-025 HALTED SHALL be terminal until Reset_n asserted; PC, AlignErr, ErrPC, InstrCount frozen; Stall/Halt/NextPC ignored.
REQ-026 InstrCount SHALL wrap 32'hFFFFFFFF -> 0 with no flag.
REQ-027 NextPC equal to current PC (self-loop) SHALL be accepted as a normal update and counted.
REQ-028 Stall and Halt asserted together: Halt wins.

Reset
REQ-029 Reset_n=0 SHALL immediately, without a clock edge, force state BOOT, PC=RESET_PC, PCValid=0, AlignErr=0, ErrPC=0, InstrCount=0.
REQ-030 Reset asserted mid-operation (any state, including mid-STALL or HALTED) SHALL produce the same values as REQ-029.
REQ-031 After Reset_n deasserts, the first edge moves to BOOT->RUN; first PC load occurs on the second edge.

Verification
REQ-032 Reset, release, NextPC=PCPlus4 for 4 edges -> PC 0,0,4,8,C; PCValid 0 then 1; InstrCount=3.
REQ-033 PC=32'h00400010, Imm16=16'hFFFE -> BranchTarget=32'h0040000C; Imm16=16'h0003 -> 32'h00400020; Instr26=26'h0000100 with same PC -> JumpTarget=32'h00000400.
REQ-034 RUN at PC=8, Stall high 3 edges then low, NextPC=32'h20 -> PC stays 8 for 4 edges (3 stall + exit), loads 32'h20 on the 5th edge; InstrCount increments once.
REQ-035 RUN, NextPC=32'h00000006 -> HALTED, AlignErr=1, ErrPC=32'h6, PCValid=0, PC unchanged; further NextPC ignored.
REQ-036 Stall=1 and Halt=1 same edge in RUN -> HALTED; then async Reset_n pulse mid-cycle -> outputs at reset values before next edge.
REQ-037 InstrCount preset near wrap via 2^32 accepted updates (or forced) -> 32'hFFFFFFFF then 0 on next accepted update.
